// File: rtl/br_issue_sched.sv
// In-order issue queue for the branch/jump unit with CDB operand wakeup and a wrong-path drain state.
// Optional build macro BR_SCHED_BYPASS_EN: a head operand arriving on the CDB this cycle issues immediately.
package br_sched_pkg;
    localparam logic [1:0] OP_BR   = 2'd0;
    localparam logic [1:0] OP_JAL  = 2'd1;
    localparam logic [1:0] OP_JALR = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [1:0]  op;
        logic [2:0]  funct3;
        logic [7:0]  rob_idx;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
    } reservation_station_t;
endpackage

module br_issue_sched
    import br_sched_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dispatch_valid,
    input  reservation_station_t dispatch_entry,
    input  logic                 dispatch_rs1_rdy,
    input  logic                 dispatch_rs2_rdy,
    input  logic [ROB_IDX_W-1:0] dispatch_rs1_tag,
    input  logic [ROB_IDX_W-1:0] dispatch_rs2_tag,
    output logic                 dispatch_ready,
    input  logic                 cdb_valid,
    input  logic [ROB_IDX_W-1:0] cdb_rob_idx,
    input  logic [31:0]          cdb_data,
    input  logic                 issue_ready,
    output reservation_station_t next_execute,
    input  logic                 br_taken,
    input  logic                 flush,
    output logic                 draining
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [PTR_W-1:0]     head, tail;
    logic [CNT_W-1:0]     count;
    logic [DEPTH-1:0]     rs1_rdy, rs2_rdy;
    logic [DEPTH-1:0]     wake1, wake2;
    logic [ROB_IDX_W-1:0] rs1_tag [DEPTH];
    logic [ROB_IDX_W-1:0] rs2_tag [DEPTH];
    reservation_station_t ent [DEPTH];

    reservation_station_t head_ent;
    logic                 head_r1, head_r2, head_ok;
    logic                 disp_wake1, disp_wake2;
    logic                 push, pop, taken_hold;

    assign dispatch_ready = rst_n && (count != CNT_W'(DEPTH)) && (state == RUN) && !flush;
    assign push           = dispatch_valid && dispatch_ready;
    assign draining       = (state == DRAIN);
    assign taken_hold     = next_execute.valid && br_taken;
    assign disp_wake1     = cdb_valid && !dispatch_rs1_rdy && (dispatch_rs1_tag == cdb_rob_idx);
    assign disp_wake2     = cdb_valid && !dispatch_rs2_rdy && (dispatch_rs2_tag == cdb_rob_idx);

    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = cdb_valid && !rs1_rdy[i] && (rs1_tag[i] == cdb_rob_idx);
            wake2[i] = cdb_valid && !rs2_rdy[i] && (rs2_tag[i] == cdb_rob_idx);
        end
    end

    always_comb begin
        head_ent = ent[head];
        head_r1  = rs1_rdy[head];
        head_r2  = rs2_rdy[head];
`ifdef BR_SCHED_BYPASS_EN
        if (wake1[head]) begin
            head_r1           = 1'b1;
            head_ent.rs1_data = cdb_data;
        end
        if (wake2[head]) begin
            head_r2           = 1'b1;
            head_ent.rs2_data = cdb_data;
        end
`endif
        head_ent.valid = 1'b1;
        // JAL needs no register operand; JALR needs only rs1
        case (head_ent.op)
            OP_JAL:  head_ok = 1'b1;
            OP_JALR: head_ok = head_r1;
            default: head_ok = head_r1 && head_r2;
        endcase
    end

    // The cycle a taken branch sits on next_execute must not issue the wrong-path successor
    assign pop = (state == RUN) && (count != '0) && head_ok && issue_ready && !flush && !taken_hold;

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = RUN;
        else if (state == RUN && taken_hold)
            state_nxt = DRAIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            rs1_rdy      <= '0;
            rs2_rdy      <= '0;
            next_execute <= '0;
        end else if (flush) begin
            state        <= RUN;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            rs1_rdy      <= '0;
            rs2_rdy      <= '0;
            next_execute <= '0;
        end else begin
            state   <= state_nxt;
            rs1_rdy <= rs1_rdy | wake1;
            rs2_rdy <= rs2_rdy | wake2;
            if (push) begin
                rs1_rdy[tail] <= dispatch_rs1_rdy | disp_wake1;
                rs2_rdy[tail] <= dispatch_rs2_rdy | disp_wake2;
                tail          <= tail + PTR_W'(1);
            end
            if (pop)
                head <= head + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
            next_execute <= pop ? head_ent : '0;
        end
    end

    // Payload, tags and operand values carry no reset; ready bits and count qualify them
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wake1[i])
                ent[i].rs1_data <= cdb_data;
            if (wake2[i])
                ent[i].rs2_data <= cdb_data;
        end
        if (push) begin
            ent[tail]     <= dispatch_entry;
            rs1_tag[tail] <= dispatch_rs1_tag;
            rs2_tag[tail] <= dispatch_rs2_tag;
            if (disp_wake1)
                ent[tail].rs1_data <= cdb_data;
            if (disp_wake2)
                ent[tail].rs2_data <= cdb_data;
        end
    end
endmodule
